// File: rtl/cache_arbiter_pkg.sv
// ============================================================================
// Module   : cache_arbiter_pkg
// Brief    : Shared types and widths for the icache/dcache memory-port arbiter.
// Config   : ARB_ROUND_ROBIN_EN (consumed by cache_arbiter)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_if.sv
// ============================================================================
// Module   : cache_arbiter_if
// Brief    : Cache-side and adaptor-side bus bundle of the memory-port arbiter.
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_arbiter_if
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned LINE_W = ARB_LINE_W
);

  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // The arbiter itself.
  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // The caches and cacheline adaptor around it.
  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module   : cache_arbiter
// Brief    : Serves one icache/dcache line transfer at a time on the shared
//            256-bit physical memory port; dcache-first or round-robin ties.
// Config   : ARB_ROUND_ROBIN_EN - defined: round-robin tie-break,
//            undefined: fixed dcache priority
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned LINE_W = ARB_LINE_W
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  arb_state_t        state_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic       w_i_req;
  logic       w_d_req;
  logic       w_d_wr;
  logic       w_pick_dcache;
  arb_owner_t w_owner;
  logic       w_i_resp;
  logic       w_d_resp;

  assign w_i_req = bus.i_pmem_read;
  assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;
  // A simultaneous read+write from the dcache is treated as a write.
  assign w_d_wr  = bus.d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_grant_q;
  assign w_pick_dcache = w_d_req & (~w_i_req | (last_grant_q == OWN_I));
`else
  assign w_pick_dcache = w_d_req;
`endif

  assign w_owner = w_pick_dcache ? OWN_D : OWN_I;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= OWN_I;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (w_i_req | w_d_req) begin
            pmem_write_q <= w_pick_dcache & w_d_wr;
            pmem_read_q  <= ~(w_pick_dcache & w_d_wr);
            addr_q       <= w_pick_dcache ? bus.d_pmem_address : bus.i_pmem_address;
            wdata_q      <= w_pick_dcache ? bus.d_pmem_wdata : '0;
            state_q      <= (w_owner == OWN_D) ? SERVE_D : SERVE_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= w_owner;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            state_q      <= DONE;
          end
        end
        // The owner may still hold its request here; it must not re-grant.
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign w_i_resp = (state_q == SERVE_I) & bus.pmem_resp;
  assign w_d_resp = (state_q == SERVE_D) & bus.pmem_resp;

  assign bus.i_pmem_resp  = w_i_resp;
  assign bus.d_pmem_resp  = w_d_resp;
  assign bus.i_pmem_rdata = w_i_resp ? bus.pmem_rdata : '0;
  assign bus.d_pmem_rdata = w_d_resp ? bus.pmem_rdata : '0;

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  a_d_rw_exclusive : assert property (
    @(posedge clk) disable iff (!rst) !(bus.d_pmem_read && bus.d_pmem_write)
  );

  a_pmem_rw_exclusive : assert property (
    @(posedge clk) !(pmem_read_q && pmem_write_q)
  );

endmodule

`default_nettype wire
